// File: rtl/instr_pkg.sv
// Shared definitions for the MIPS instruction encoder: format codes, field
// bit positions, default base address and the NOP word.
package instr_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_NOP = 2'd3
    } fmt_t;

    localparam int OP_HI = 31;
    localparam int RS_HI = 25;
    localparam int RT_HI = 20;
    localparam int RD_HI = 15;
    localparam int SH_HI = 10;
    localparam int FN_HI = 5;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

endpackage

// File: rtl/instr_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush. Pointers carry one extra
// MSB so full and empty can be told apart when the index bits match.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage is not reset; entries are only observed once the write pointer has passed them.
    always_ff @(posedge clk) begin
        if (reset && !flush && push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded MIPS fields into 32-bit words, queues them and emits each with
// its IM address. Optional field-consistency check: define ENC_FIELD_CHECK_EN.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic [15:0] count,
    output logic        fmt_err
);

    logic [31:0] word;
    logic [31:0] head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    always_comb begin
        word = NOP_WORD;
        case (fmt_t'(fmt))
            FMT_R: begin
                word[OP_HI -: 6] = opcode;
                word[RS_HI -: 5] = rs;
                word[RT_HI -: 5] = rt;
                word[RD_HI -: 5] = rd;
                word[SH_HI -: 5] = shamt;
                word[FN_HI -: 6] = func;
            end
            FMT_I: begin
                word[OP_HI -: 6]  = opcode;
                word[RS_HI -: 5]  = rs;
                word[RT_HI -: 5]  = rt;
                word[RD_HI:0]     = imm16;
            end
            FMT_J: begin
                word[OP_HI -: 6] = opcode;
                word[RS_HI:0]    = imm26;
            end
            default: word = NOP_WORD;
        endcase
    end

    // A flush cycle swallows any handshake so the restart is clean.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign instr     = empty ? NOP_WORD : head;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            addr  <= BASE_ADDR;
            count <= '0;
        end else if (pop) begin
            addr <= addr + 32'd4;
            if (count != 16'hFFFF) begin
                count <= count + 16'd1;
            end
        end
    end

`ifdef ENC_FIELD_CHECK_EN
    logic field_bad;

    assign field_bad = ((fmt_t'(fmt) == FMT_R) && (opcode != 6'd0)) ||
                       ((fmt_t'(fmt) == FMT_NOP) &&
                        (|{opcode, rs, rt, rd, shamt, func, imm16, imm26}));

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fmt_err <= 1'b0;
        end else if (push && field_bad) begin
            fmt_err <= 1'b1;
        end
    end
`else
    assign fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder; expected words and addresses are
// hand-computed. Covers the ENC_FIELD_CHECK_EN build when the macro is defined.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [15:0] count;
    logic        fmt_err;

    int vectors;
    int miscompares;

    instr_encoder #(
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .func      (func),
        .imm16     (imm16),
        .imm26     (imm26),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .addr      (addr),
        .count     (count),
        .fmt_err   (fmt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn);
        fmt = 2'd0; opcode = op; rs = s; rt = t; rd = d; shamt = sh; func = fn;
        imm16 = 16'hDEAD; imm26 = 26'h2BEEF00;
    endtask

    task automatic set_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [15:0] imm);
        fmt = 2'd1; opcode = op; rs = s; rt = t; imm16 = imm;
        rd = 5'h1F; shamt = 5'h15; func = 6'h3F; imm26 = 26'h3FFFFFF;
    endtask

    task automatic set_j(input logic [5:0] op, input logic [25:0] imm);
        fmt = 2'd2; opcode = op; imm26 = imm;
        rs = 5'h1F; rt = 5'h1F; rd = 5'h1F; shamt = 5'h1F; func = 6'h3F; imm16 = 16'hFFFF;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        repeat (2) tick();
        vectors++;
        if (out_valid !== 1'b0 || instr !== 32'h0 || addr !== 32'h3000 ||
            count !== 16'h0 || fmt_err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got v=%b i=%h a=%h c=%h e=%b r=%b expected 0 0 3000 0 0 1",
                     out_valid, instr, addr, count, fmt_err, in_ready);
        end
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_r_format();
        do_flush();
        set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || instr !== 32'h0022_1821 || addr !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL r_word: got v=%b i=%h a=%h expected 1 00221821 3000",
                     out_valid, instr, addr);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || count !== 16'd1 || addr !== 32'h3004) begin
            miscompares++;
            $display("[TB] FAIL r_pop: got v=%b c=%0d a=%h expected 0 1 3004", out_valid, count, addr);
        end
    endtask

    task automatic test_i_j();
        do_flush();
        set_i(6'h0D, 5'd0, 5'd8, 16'h1234);
        in_valid = 1'b1;
        tick();
        set_j(6'h02, 26'h0000C00);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (instr !== 32'h3408_1234 || addr !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL i_word: got i=%h a=%h expected 34081234 3000", instr, addr);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || instr !== 32'h0800_0C00 || addr !== 32'h3004) begin
            miscompares++;
            $display("[TB] FAIL j_word: got v=%b i=%h a=%h expected 1 08000c00 3004", out_valid, instr, addr);
        end
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || count !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL ij_drain: got v=%b c=%0d expected 0 2", out_valid, count);
        end
    endtask

    task automatic test_full_hold();
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_i(6'h08, 5'd0, 5'd0, 16'hA000 + 16'(i));
            in_valid = 1'b1;
            vectors++;
            if (in_ready !== (i < 4)) begin
                miscompares++;
                $display("[TB] FAIL in_ready_%0d: got %b expected %b", i, in_ready, (i < 4));
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (in_ready !== 1'b0 || instr !== 32'h2000_A000 || addr !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL hold_stable: got r=%b i=%h a=%h expected 0 2000a000 3000", in_ready, instr, addr);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || instr !== (32'h2000_A000 + 32'(k)) || addr !== (32'h3000 + 32'(4 * k))) begin
                miscompares++;
                $display("[TB] FAIL drain_%0d: got v=%b i=%h a=%h expected 1 %h %h", k, out_valid, instr, addr,
                         32'h2000_A000 + 32'(k), 32'h3000 + 32'(4 * k));
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || count !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL drain_end: got v=%b c=%0d expected 0 4", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_flush();
        for (int i = 0; i < 4; i++) begin
            set_i(6'h08, 5'd0, 5'd0, 16'hA100 + 16'(i));
            in_valid = 1'b1;
            tick();
        end
        set_i(6'h08, 5'd0, 5'd0, 16'hBBBB);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || instr !== 32'h2000_A101 || addr !== 32'h3004) begin
            miscompares++;
            $display("[TB] FAIL full_push_pop: got r=%b i=%h a=%h expected 1 2000a101 3004", in_ready, instr, addr);
        end
        out_ready = 1'b1;
        n = 0;
        for (int g = 0; g < 10 && out_valid; g++) begin
            n++;
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (n !== 3 || count !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL occupancy: got words=%0d c=%0d expected 3 4", n, count);
        end
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 2; i++) begin
            set_i(6'h08, 5'd0, 5'd0, 16'hC000 + 16'(i));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_i(6'h08, 5'd0, 5'd0, 16'hCCCC);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || count !== 16'd0 || addr !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL flush_state: got v=%b c=%0d a=%h expected 0 0 3000", out_valid, count, addr);
        end
        set_j(6'h03, 26'h0000040);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || instr !== 32'h0C00_0040 || addr !== 32'h3000) begin
            miscompares++;
            $display("[TB] FAIL post_flush: got v=%b i=%h a=%h expected 1 0c000040 3000", out_valid, instr, addr);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_field_check();
        do_flush();
        set_r(6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ENC_FIELD_CHECK_EN
        vectors++;
        if (fmt_err !== 1'b1 || out_valid !== 1'b1 || instr !== 32'h8C22_1800) begin
            miscompares++;
            $display("[TB] FAIL fmt_err_set: got e=%b v=%b i=%h expected 1 1 8c221800", fmt_err, out_valid, instr);
        end
        do_flush();
        vectors++;
        if (fmt_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fmt_err_flush: got %b expected 1", fmt_err);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if (fmt_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fmt_err_reset: got %b expected 0", fmt_err);
        end
`else
        vectors++;
        if (fmt_err !== 1'b0 || out_valid !== 1'b1 || instr !== 32'h8C22_1800) begin
            miscompares++;
            $display("[TB] FAIL fmt_err_off: got e=%b v=%b i=%h expected 0 1 8c221800", fmt_err, out_valid, instr);
        end
        do_flush();
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_r(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0);
        test_reset();
        test_r_format();
        test_i_j();
        test_full_hold();
        test_back_to_back();
        test_flush();
        test_field_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name:
instr_encoder

Overview:
- Inverse of the instruction field splitter: packs decoded fields (opcode, rs, rt, rd, shamt, func, imm16, imm26) into 32-bit MIPS words.
- Buffers encoded words in a small FIFO and emits each one with its instruction-memory address.
- Sits between the test-program generator / loader and the IM write port; the CPU bench uses it to fill instruction memory.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- BASE_ADDR, 32'h0000_3000, address assigned to the first emitted word.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous; drops FIFO contents and restarts addressing at BASE_ADDR
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- fmt  in  2  0=R, 1=I, 2=J, 3=NOP
- opcode  in  6  Instr[31:26]
- rs  in  5  Instr[25:21]
- rt  in  5  Instr[20:16]
- rd  in  5  Instr[15:11]
- shamt  in  5  Instr[10:6]
- func  in  6  Instr[5:0]
- imm16  in  16  Instr[15:0], I format
- imm26  in  26  Instr[25:0], J format
- out_valid  out  1  head word valid
- out_ready  in  1  sink accepts the head word
- instr  out  32  encoded word at the FIFO head
- addr  out  32  IM address of the head word
- count  out  16  words emitted since reset/flush, saturating
- fmt_err  out  1  sticky field-consistency error (optional feature only)

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO empty; pointers = 0.
  - out_valid=0, instr=0, addr=BASE_ADDR, count=0, fmt_err=0.
  - Reset overrides flush and any handshake in the same cycle.
- Encoding (combinational from the input bundle, registered on push):
  - R: {opcode,rs,rt,rd,shamt,func}
  - I: {opcode,rs,rt,imm16}
  - J: {opcode,imm26}
  - NOP: 32'h0000_0000
  - Fields not used by the selected format are ignored.
- Push: in_valid && in_ready. in_ready = !full, independent of out_ready (no combinational ready path).
- Pop: out_valid && out_ready. out_valid = !empty. instr is the head entry, valid the cycle after push (latency 1).
- Push and pop in the same cycle:
  - Both take effect; occupancy is unchanged.
  - When empty, only push occurs, because pop requires out_valid.
  - When full, only pop occurs, because push requires in_ready.
- Pointers: log2(DEPTH)+1 bits; the MSB distinguishes full from empty; they wrap modulo 2*DEPTH.
- addr:
  - Register holding the address of the head word; +4 on each pop.
  - Wraps modulo 2^32.
  - Head address = BASE_ADDR + 4*(number of pops).
- count: +1 per pop; saturates at 16'hFFFF.
- flush:
  - Next cycle: FIFO empty, addr=BASE_ADDR, count=0.
  - Any push or pop in the flush cycle is discarded.
  - fmt_err is not cleared.
- Output stability: while out_valid && !out_ready, instr and addr must remain stable.

Optional Feature:
- Macro: ENC_FIELD_CHECK_EN.
- Defined: fmt_err goes high, sticky until reset, on any accepted push where:
  - fmt==R and opcode!=0, or
  - fmt==NOP and any field is nonzero.
  - The word is still encoded and pushed normally.
- Undefined: fmt_err is tied to 0 and no check logic is present.

Decomposition:
- Shared package instr_pkg holds:
  - fmt encodings FMT_R/FMT_I/FMT_J/FMT_NOP;
  - field bit positions (OP_HI=31, RS_HI=25, RT_HI=20, RD_HI=15, SH_HI=10, FN_HI=5);
  - BASE_ADDR default;
  - NOP word.
- One sub-module: instr_fifo, a generic DEPTH x 32 synchronous FIFO with push/pop/flush and full/empty.
- Encoding mux, address counter and emitted-word counter stay in instr_encoder.

Test Plan:
- Reset, then push R: opcode=0, rs=1, rt=2, rd=3, shamt=0, func=6'h21, sink ready -> next cycle out_valid=1, instr=32'h0022_1821, addr=32'h3000; after pop, count=1.
- Push I: opcode=6'h0D, rs=0, rt=8, imm16=16'h1234, then J: opcode=6'h02, imm26=26'h0C00 -> instr=32'h3408_1234 @3000, then 32'h0800_0C00 @3004.
- Hold out_ready=0 and push 5 bundles -> in_ready falls after 4; the 5th is not accepted; instr/addr hold stable; raising out_ready drains 4 words in order with addresses 3000..300C.
- Full FIFO, then simultaneous pop and push -> one pop only; next cycle in_ready=1 and occupancy=3.
- Push 2 words, pulse flush together with a push -> out_valid=0, count=0, next pushed word emitted at addr 32'h3000.
- With ENC_FIELD_CHECK_EN: push R with opcode=6'h23 -> fmt_err=1 and word still emitted; fmt_err survives flush and clears only on reset.
